// File: rtl/byte_combiner_if.sv
// Byte-in / word-out handshake bundle for byte_combiner.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds valid and data stable until that edge, and ready never waits on valid.
interface byte_combiner_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_word
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_word
    );
endinterface

// File: rtl/byte_combiner.sv
// Packs four consecutive bytes (first byte most significant) into a 32-bit word
// held in a one-entry output register; byte_cnt plus out_valid is the whole state.
module byte_combiner (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    byte_combiner_if.slave        bus,
    output logic [1:0]            byte_cnt
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] partial_q, partial_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic        in_ready;
    logic        in_fire;
    logic        out_fire;

    // Only the completing byte can stall, and only when the held word is not draining.
    assign in_ready = ~clear & ~((cnt_q == 2'd3) & valid_q & ~bus.out_ready);
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = valid_q & bus.out_ready;

    always_comb begin
        cnt_d     = cnt_q;
        partial_d = partial_q;
        word_d    = word_q;
        valid_d   = valid_q;
        if (out_fire) begin
            valid_d = 1'b0;
        end
        if (in_fire) begin
            if (cnt_q == 2'd3) begin
                word_d    = {partial_q, bus.in_byte};
                valid_d   = 1'b1;
                cnt_d     = 2'd0;
                partial_d = 24'd0;
            end else begin
                partial_d = {partial_q[15:0], bus.in_byte};
                cnt_d     = cnt_q + 2'd1;
            end
        end else if (clear) begin
            cnt_d     = 2'd0;
            partial_d = 24'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= 2'd0;
            partial_q <= 24'd0;
            word_q    <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_word  = word_q;
    assign byte_cnt      = cnt_q;
endmodule

// File: tb/tb_byte_combiner.sv
// Bench for byte_combiner: directed scenarios plus random traffic against a
// byte-queue / word-queue reference model.
module tb_byte_combiner;
    logic       clk;
    logic       reset;
    logic       clear;
    logic [1:0] byte_cnt;

    byte_combiner_if bus ();

    byte_combiner u_dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bus      (bus.slave),
        .byte_cnt (byte_cnt)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model and scoreboard
    logic [7:0]  byte_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_word;
    int          checks;
    int          errors;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        byte_q.delete();
        exp_q.delete();
        m_word = 32'd0;
    endtask

    // Driver: entered at a falling edge, drives one cycle, checks, advances model.
    task automatic cycle(input logic v, input logic [7:0] b, input logic ordy, input logic clr);
        logic exp_rdy;
        logic m_valid;
        logic in_fire;
        logic out_fire;
        bus.in_valid  = v;
        bus.in_byte   = b;
        bus.out_ready = ordy;
        clear         = clr;
        #1;
        m_valid = (exp_q.size() != 0);
        exp_rdy = !clr && !(byte_q.size() == 3 && m_valid && !ordy);
        check_eq("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        check_eq("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        check_eq("byte_cnt", {30'd0, byte_cnt}, byte_q.size());
        check_eq("out_word", bus.out_word, m_word);
        in_fire  = v && exp_rdy;
        out_fire = m_valid && ordy;
        if (out_fire) begin
            check_eq("drained_word", bus.out_word, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (in_fire) begin
            byte_q.push_back(b);
            if (byte_q.size() == 4) begin
                m_word = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
                exp_q.push_back(m_word);
                byte_q.delete();
            end
        end else if (clr) begin
            byte_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send4(input logic [31:0] w, input logic ordy);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w << (8 * i);
            cycle(1'b1, t[31:24], ordy, 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        reset         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;
        #1;
        check_eq("reset_byte_cnt", {30'd0, byte_cnt}, 32'd0);
        check_eq("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("reset_out_word", bus.out_word, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 12,34,56,78 then idle
        send4(32'h12345678, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // back-to-back 01..08
        send4(32'h01020304, 1'b1);
        send4(32'h05060708, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // stall on completing byte, then drain+load on the same edge
        send4(32'hAABBCCDD, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("stall_word", bus.out_word, 32'hEEFF1122);

        // clear mid-group
        cycle(1'b1, 8'h12, 1'b1, 1'b0);
        cycle(1'b1, 8'h34, 1'b1, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b1);
        send4(32'h56789ABC, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("clear_word", bus.out_word, 32'h56789ABC);

        // clear with byte_cnt == 0 and a word pending
        send4(32'hCAFEF00D, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h55, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // asynchronous reset mid-group with a word pending
        send4(32'h0BADBEEF, 1'b0);
        cycle(1'b1, 8'h12, 1'b0, 1'b0);
        cycle(1'b1, 8'h34, 1'b0, 1'b0);
        cycle(1'b1, 8'h56, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("async_byte_cnt", {30'd0, byte_cnt}, 32'd0);
        check_eq("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("async_out_word", bus.out_word, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        send4(32'h789ABCDE, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("post_reset_word", bus.out_word, 32'h789ABCDE);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        for (int n = 0; n < 4; n++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("final_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/byte_combiner.md
# byte_combiner

Serial-to-parallel counterpart of the byte splitter: accepts a stream of 8-bit bytes over a valid/ready handshake and packs every four consecutive bytes into one 32-bit word, first byte in the most significant position. The finished word is held in a one-entry output register with its own valid/ready handshake. It sits between a byte-wide source (e.g. a serial receiver) and word-wide consumers (register file, memory write port).

## Interface
- No parameters. Fixed at 4 bytes × 8 bits = 32-bit word.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous discard of partially assembled bytes.
- in_valid  in  1  in_byte holds a byte.
- in_ready  out  1  combiner can accept a byte this cycle.
- in_byte  in  8  input byte.
- out_valid  out  1  out_word holds a complete word.
- out_ready  in  1  consumer takes out_word this cycle.
- out_word  out  32  assembled word.
- byte_cnt  out  2  bytes currently held in the partial word (0–3).

## Operation
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- Packing order: byte k of a group (k = 0..3, arrival order) lands in bits [31-8k : 24-8k]. Bytes 12,34,56,78 produce 0x12345678.
- Partial register: a 24-bit shift register plus byte_cnt.
  - Transfer with byte_cnt < 3: byte stored, byte_cnt increments.
  - Transfer with byte_cnt == 3: {partial, in_byte} loads out_word, out_valid sets, byte_cnt wraps to 0.
- in_ready = ~clear & ~(byte_cnt == 3 & out_valid & ~out_ready).
  - Bytes 0–2 are always accepted, even while an output word is pending.
  - Only the completing byte stalls, and only while the output register is full and not draining.
- out_valid clears on an output transfer, unless a completing byte is accepted in the same cycle; then it stays 1 and out_word takes the new word.
- out_word is stable while out_valid=1 and out_ready=0.
- clear:
  - Sets byte_cnt to 0 and discards the partial bytes.
  - in_ready is 0 while clear=1, so no byte is lost silently.
  - Does not affect out_valid or out_word. A pending word still drains normally, including in the same cycle.
- States are implicit in byte_cnt (0..3) and out_valid (EMPTY/FULL). No other state is kept.

## Timing
- Reset (asynchronous, reset=0): byte_cnt=0, partial=0, out_word=0x00000000, out_valid=0. Outputs are valid immediately, without waiting for clk.
  - in_ready is 1 once reset is released, provided clear=0.
- Reset asserted mid-group or with a word pending: all state is lost. No word is emitted afterwards.
- Latency: out_valid rises at the same edge that accepts the 4th byte. Input-to-output latency is 1 cycle.
- Throughput: 1 byte/cycle sustained, 1 word per 4 cycles, provided out_ready is asserted at least once every 4 cycles.
- Back-to-back operation: with out_ready held at 1, out_valid is high for exactly 1 cycle per word.
- Boundary cases:
  - byte_cnt == 3, out_valid=1, out_ready=1, in_valid=1: the old word drains and the new word loads at the same edge. No bubble.
  - byte_cnt == 3, out_valid=1, out_ready=0: in_ready=0. byte_cnt and partial hold.
  - clear with byte_cnt == 0: no effect.
  - in_valid while in_ready=0: no state change. The source must hold in_byte.

## Test plan
- Reset, then bytes 12,34,56,78 on consecutive cycles with out_ready=1 -> out_valid high for 1 cycle after the 4th byte, out_word=0x12345678, byte_cnt returns to 0.
- Eight consecutive bytes 01..08 with out_ready=1 -> words 0x01020304 then 0x05060708, 4 cycles apart, in_ready constantly 1.
- Send AA,BB,CC,DD with out_ready=0, then EE,FF,11 -> all accepted, byte_cnt=3. Present 22 -> in_ready=0 and out_word stays 0xAABBCCDD. Raise out_ready -> 0xAABBCCDD drains and 0xEEFF1122 loads on the same edge.
- Send 12,34, assert clear for 1 cycle with in_valid=1 and in_byte=99 -> in_ready=0, byte_cnt=0. Then 56,78,9A,BC -> out_word=0x56789ABC.
- Send 12,34,56, drive reset low between clock edges -> byte_cnt, out_valid and out_word are 0 immediately. After release, bytes 78,9A,BC,DE -> 0x789ABCDE.
- Word pending with out_ready=0, then clear=1 -> out_valid stays 1 and out_word is unchanged until out_ready=1.
